// File: rtl/nibble_serial_add_seq.sv
// rtl/nibble_serial_add_seq.sv - nibble-serial WIDTH-bit adder sequencer driving an external 4-bit CLA
module nibble_serial_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SEL_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry_reg;
    logic               cin_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   work;
    logic [SEL_W-1:0]   base;
    logic               accept;
    logic               last;
    logic               final_msb;

    assign base      = SEL_W'(idx) << 2;
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last      = (state == S_RUN) && (idx == LAST_IDX);
    assign final_msb = cla_sum[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (idx == LAST_IDX) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Adder inputs are driven only while running so the CLA sees quiet zeros otherwise.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        cla_a   = 4'd0;
        cla_b   = 4'd0;
        cla_cin = 1'b0;
        case (state)
            S_RUN: begin
                busy    = 1'b1;
                cla_a   = a_reg[base +: 4];
                cla_b   = b_reg[base +: 4];
                cla_cin = (idx == '0) ? cin_reg : carry_reg;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            cin_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= carry_in;
            idx     <= '0;
        end else if (state == S_RUN) begin
            work[base +: 4] <= cla_sum;
            carry_reg       <= cla_cout;
            if (last) begin
                // Top nibble comes straight from the adder; lower nibbles are already in work.
                sum       <= {cla_sum, work[WIDTH-5:0]};
                carry_out <= cla_cout;
                overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (final_msb != a_reg[WIDTH-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
- Sequencer that performs WIDTH-bit addition one 4-bit nibble per clock, using the team's existing 4-bit carry-lookahead adder as its datapath.
- Drives the adder's A/B/carry_in and consumes its sum/carry_out. Chains the carry through a register between cycles.
- Sits directly upstream and downstream of the 4-bit adder and is the wide-operand front end for the ALU datapath.
- Adder is instantiated outside this block, so both are verified together.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, number of RUN cycles; local/derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, sampled when start is accepted
- b  input  WIDTH  operand B, sampled when start is accepted
- carry_in  input  1  initial carry, sampled when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result
- carry_out  output  1  registered final carry
- overflow  output  1  registered two's-complement overflow
- cla_a  output  4  nibble to adder input A
- cla_b  output  4  nibble to adder input B
- cla_cin  output  1  to adder carry_in
- cla_sum  input  4  from adder sum
- cla_cout  input  1  from adder carry_out

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, carry register=0.
  - All operand latches = 0.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
- States:
  - IDLE: waits for start.
  - RUN: processes one nibble per cycle.
  - DONE: one cycle, done=1.
- Start acceptance:
  - In IDLE or DONE, start=1 at an edge latches a, b and carry_in, sets idx=0 and moves to RUN.
  - start in RUN is ignored; no effect on the operation in flight.
- Adder drive in RUN (combinational from registers):
  - cla_a = a_reg[4*idx+3 : 4*idx], cla_b = b_reg[4*idx+3 : 4*idx].
  - cla_cin = carry_in latch when idx=0, else carry register.
  - Outside RUN, cla_a=0, cla_b=0, cla_cin=0.
- Each RUN edge:
  - work[4*idx+3 : 4*idx] <= cla_sum and carry register <= cla_cout.
  - If idx=NIBBLES-1: go to DONE; else idx <= idx+1.
- Final RUN edge (same edge):
  - sum <= completed work value, carry_out <= cla_cout.
  - overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (final sum[WIDTH-1] != a_reg[WIDTH-1]).
  - sum, carry_out and overflow hold their previous values until this edge.
- DONE:
  - done=1, busy=0.
  - Next edge goes to IDLE, or to RUN if start=1 (back-to-back, no bubble).
- Latency: start accepted at edge k gives busy=1 for edges k+1 through k+NIBBLES, results valid after edge k+NIBBLES, and done=1 in the cycle after edge k+NIBBLES.
- Timing: the adder's internal path delay (about 100 ps worst case) must settle within one cycle. Bench clock period is 200 ps, timescale 1ps/1fs.
- Reset mid-RUN: abort immediately, all outputs return to reset values, done is not pulsed.
- Arithmetic: unsigned modulo 2^WIDTH. carry_out is the bit-WIDTH carry; overflow uses signed interpretation.

Test Plan:
- Reset, then start with a=0x1234, b=0x4321, carry_in=0 -> busy for 4 cycles, done pulse, sum=0x5555, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, carry_in=0 -> carry ripples through every nibble: sum=0x0000, carry_out=1, overflow=0. Check cla_cin=1 on idx 1-3.
- a=0x7FFF, b=0x0000, carry_in=1 -> sum=0x8000, carry_out=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- Start pulsed again mid-RUN with different operands -> ignored; first result unchanged and exactly one done pulse.
- start held high during the DONE cycle with a=0x0F0F, b=0x0101 -> next op begins with no idle cycle; sum=0x1010 four cycles later.
- Assert rst_n low at idx=2 -> all outputs go to 0 asynchronously, no done. A new start after release gives a correct result.
